instr_mem_responder: RTL

- Synthesizable instruction-memory slave for the core's instruction-fetch port (OBI-style req/gnt/rvalid).
- It is the responder end of the fetch handshake. It grants fetch requests, reads a word-addressed memory array and returns instruction words in order after a fixed latency.
- The bench preloads it through a dedicated load port. It supports grant-stall injection and bounded outstanding transactions, so register-file tests can run against RTL memory instead of the UVM driver.

---
 rtl/instr_mem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: OBI-style instruction-fetch slave with preload port, grant stall
// and fixed-latency in-order responses from a word-addressed array.
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] OOR_DATA        = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [31:0]                    instr_rdata_o,
    input  logic                           gnt_stall_i,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                    load_data_i,
    output logic                           err_o,
    output logic [31:0]                    rsp_count_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned L  = RVALID_LATENCY;
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [L-1:0]  valid_q, valid_d;
    logic [31:0]   data_q [L];
    logic [31:0]   data_d [L];
    logic [OW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   word;
    logic [31:0]   rd_data;
    logic          oor;

    assign word    = (instr_addr_i - BASE_ADDR) >> 2;
    assign oor     = (instr_addr_i < BASE_ADDR) | (word >= DEPTH_WORDS);
    assign rd_data = oor ? OOR_DATA : mem[word[AW-1:0]];

    // A response retiring this cycle frees its slot for a same-cycle grant
    assign instr_gnt_o    = rst_n & instr_req_i & ~gnt_stall_i & ((out_q < MAX_O) | valid_q[L-1]);
    assign instr_rvalid_o = valid_q[L-1];
    assign instr_rdata_o  = data_q[L-1];
    assign err_o          = err_q;
    assign rsp_count_o    = cnt_q;

    // Data only advances behind a valid entry so the last stage holds the last delivered word
    always_comb begin
        valid_d[0] = instr_gnt_o;
        data_d[0]  = instr_gnt_o ? rd_data : data_q[0];
        for (int i = 1; i < L; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
        out_d = out_q + OW'(instr_gnt_o) - OW'(valid_q[L-1]);
        err_d = err_q | (instr_gnt_o & (oor | (instr_addr_i[1:0] != 2'b00)));
        cnt_d = cnt_q + 32'(valid_q[L-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < L; i++) data_q[i] <= '0;
            out_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < L; i++) data_q[i] <= data_d[i];
            out_q <= out_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we_i) mem[load_addr_i] <= load_data_i;
    end
endmodule
